// File: rtl/key_conditioner.sv
// key_conditioner: three-channel pushbutton debouncer with press/release pulses and per-key auto-repeat.
module key_conditioner #(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [2:0] rpt_en,
  output logic [2:0] key_level,
  output logic [2:0] key_press,
  output logic [2:0] key_release,
  output logic [2:0] key_repeat
);
  localparam int MAX_A = DB_CYCLES > RPT_DELAY ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_C = MAX_A > RPT_PERIOD ? MAX_A : RPT_PERIOD;
  localparam int W = $clog2(MAX_C);
  localparam logic [W-1:0] DB_MAX  = W'(DB_CYCLES - 1);
  localparam logic [W-1:0] RD_MAX  = W'(RPT_DELAY - 1);
  localparam logic [W-1:0] RP_MAX  = W'(RPT_PERIOD - 1);
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK} state_t;
  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];
  genvar i;
  for (i = 0; i < 3; i++) begin : g_ch
    state_t st, nxt;
    logic [W-1:0] cnt, cnt_d;
    logic [1:0] sync;
    logic sync_p, press_d, rel_d, rpt_d;
    assign sync_p = ~sync[1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync           <= 2'b11;
        st             <= IDLE;
        cnt            <= '0;
        key_level[i]   <= 1'b0;
        key_press[i]   <= 1'b0;
        key_release[i] <= 1'b0;
        key_repeat[i]  <= 1'b0;
      end else begin
        sync           <= {sync[0], KEY[i+1]};
        st             <= nxt;
        cnt            <= cnt_d;
        key_level[i]   <= nxt == HELD || nxt == REPEAT || nxt == REL_CHK;
        key_press[i]   <= press_d;
        key_release[i] <= rel_d;
        key_repeat[i]  <= rpt_d;
      end
    end
    // every non-transition path counts up and holds at its own limit
    always_comb begin
      nxt     = st;
      cnt_d   = cnt;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;
      case (st)
        IDLE: begin
          nxt   = sync_p ? PRESS_CHK : IDLE;
          cnt_d = '0;
        end
        PRESS_CHK: begin
          if (!sync_p) begin
            nxt   = IDLE;
            cnt_d = '0;
          end else if (cnt == DB_MAX) begin
            nxt     = HELD;
            press_d = 1'b1;
            cnt_d   = '0;
          end else cnt_d = cnt + 1'b1;
        end
        HELD: begin
          if (!sync_p) begin
            nxt   = REL_CHK;
            cnt_d = '0;
          end else if (rpt_en[i] && cnt == RD_MAX) begin
            nxt   = REPEAT;
            rpt_d = 1'b1;
            cnt_d = '0;
          end else cnt_d = cnt == RD_MAX ? cnt : cnt + 1'b1;
        end
        REPEAT: begin
          if (!sync_p) begin
            nxt   = REL_CHK;
            cnt_d = '0;
          end else if (!rpt_en[i]) begin
            nxt   = HELD;
            cnt_d = RD_MAX;
          end else if (cnt == RP_MAX) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else cnt_d = cnt + 1'b1;
        end
        REL_CHK: begin
          if (sync_p) begin
            nxt   = HELD;
            cnt_d = '0;
          end else if (cnt == DB_MAX) begin
            nxt   = IDLE;
            rel_d = 1'b1;
            cnt_d = '0;
          end else cnt_d = cnt + 1'b1;
        end
        default: begin
          nxt   = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, glitch rejection, auto-repeat and async reset.
module tb_key_conditioner;
  logic       clk = 1'b0;
  logic [3:0] key = 4'b1111;
  logic [2:0] rpt_en = 3'b000;
  logic [2:0] level, press, rel, rpt;
  int total = 0;
  int fails = 0;

  key_conditioner #(.DB_CYCLES(8), .RPT_DELAY(20), .RPT_PERIOD(5)) dut (
    .CLOCK_50(clk), .KEY(key), .rpt_en(rpt_en),
    .key_level(level), .key_press(press), .key_release(rel), .key_repeat(rpt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: got %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic [2:0] l, input logic [2:0] p,
                         input logic [2:0] r, input logic [2:0] t);
    chk({tag, "_level"}, e, level, l);
    chk({tag, "_press"}, e, press, p);
    chk({tag, "_release"}, e, rel, r);
    chk({tag, "_repeat"}, e, rpt, t);
  endtask

  initial begin
    #2 key = 4'b1110;
    #1 chk_all("rst_async", 0, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(2);
    chk_all("rst_hold", 0, 3'b000, 3'b000, 3'b000, 3'b000);
    key[0] = 1'b1;
    tick(3);
    // single press/release on channel 0, repeat disabled
    key[1] = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      tick(1);
      chk_all("basic", e, (e >= 11 && e <= 50) ? 3'b001 : 3'b000, e == 11 ? 3'b001 : 3'b000,
              e == 51 ? 3'b001 : 3'b000, 3'b000);
      if (e == 40) key[1] = 1'b1;
    end
    tick(3);
    // short glitch on channel 1 is rejected
    key[2] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      chk_all("glitch", e, 3'b000, 3'b000, 3'b000, 3'b000);
      if (e == 5) key[2] = 1'b1;
    end
    // auto-repeat on channel 2
    rpt_en = 3'b100;
    key[3] = 1'b0;
    for (int e = 1; e <= 62; e++) begin
      tick(1);
      chk_all("repeat", e, (e >= 11 && e <= 60) ? 3'b100 : 3'b000, e == 11 ? 3'b100 : 3'b000,
              e == 61 ? 3'b100 : 3'b000,
              (e == 31 || e == 36 || e == 41 || e == 46 || e == 51) ? 3'b100 : 3'b000);
      if (e == 50) key[3] = 1'b1;
    end
    rpt_en = 3'b000;
    tick(3);
    // release bounce while held restarts the repeat delay with no release pulse
    rpt_en = 3'b001;
    key[1] = 1'b0;
    for (int e = 1; e <= 56; e++) begin
      tick(1);
      chk_all("bounce", e, (e >= 11 && e <= 54) ? 3'b001 : 3'b000, e == 11 ? 3'b001 : 3'b000,
              e == 55 ? 3'b001 : 3'b000, (e == 38 || e == 43) ? 3'b001 : 3'b000);
      if (e == 12) key[1] = 1'b1;
      if (e == 15) key[1] = 1'b0;
      if (e == 44) key[1] = 1'b1;
    end
    rpt_en = 3'b000;
    tick(3);
    // simultaneous press and release on channels 0 and 2
    key[1] = 1'b0;
    key[3] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      chk_all("simul_p", e, e >= 11 ? 3'b101 : 3'b000, e == 11 ? 3'b101 : 3'b000, 3'b000, 3'b000);
    end
    key[1] = 1'b1;
    key[3] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      chk_all("simul_r", e, e <= 10 ? 3'b101 : 3'b000, 3'b000, e == 11 ? 3'b101 : 3'b000, 3'b000);
    end
    tick(3);
    // async reset mid-hold on channel 1, then re-press with key still down
    key[2] = 1'b0;
    tick(15);
    chk_all("pre_rst", 15, 3'b010, 3'b000, 3'b000, 3'b000);
    #2 key[0] = 1'b0;
    #1 chk_all("mid_rst", 0, 3'b000, 3'b000, 3'b000, 3'b000);
    #1 key[0] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick(1);
      chk_all("post_rst", e, e >= 11 ? 3'b010 : 3'b000, e == 11 ? 3'b010 : 3'b000, 3'b000, 3'b000);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, stable cycles required to accept a level change (20 ms at 50 MHz); SHALL be >= 2.
REQ-002 Parameter RPT_DELAY, default 25000000, cycles from accepted press to first repeat (500 ms); SHALL be >= 2.
REQ-003 Parameter RPT_PERIOD, default 5000000, cycles between subsequent repeats (100 ms); SHALL be >= 2.
REQ-004 CLOCK_50  input  1  single system clock; all state on its rising edge.
REQ-005 KEY  input  4  KEY[0] asynchronous active-low reset, KEY[3:1] raw active-low pushbuttons; one clock, reset asynchronous and active-low.
REQ-006 rpt_en  input  3  per-key auto-repeat enable, bit i for KEY[i+1], sampled every cycle.
REQ-007 key_level  output  3  debounced state, 1 = pressed.
REQ-008 key_press  output  3  one-cycle pulse on accepted press.
REQ-009 key_release  output  3  one-cycle pulse on accepted release.
REQ-010 key_repeat  output  3  one-cycle pulse per auto-repeat tick.

Function
REQ-011 Each KEY[i+1] SHALL pass through a 2-flop synchronizer, then be inverted (sync_p = 1 means pressed); the three channels are independent identical instances.
REQ-012 Each channel SHALL run one FSM with states IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK and one counter sized by $clog2 of the largest parameter.
REQ-013 IDLE: sync_p=1 -> PRESS_CHK, counter cleared.
REQ-014 PRESS_CHK: sync_p=0 -> IDLE, no output (glitch rejected); counter reaching DB_CYCLES-1 with sync_p=1 -> HELD, key_press pulse, key_level<=1, counter cleared.
REQ-015 Press latency SHALL be exactly DB_CYCLES+3 edges from the first edge sampling KEY low to the edge registering key_press high, given KEY held low throughout.
REQ-016 HELD: sync_p=0 -> REL_CHK, counter cleared; with rpt_en=1 and counter reaching RPT_DELAY-1 -> REPEAT, key_repeat pulse, counter cleared; with rpt_en=0 counter saturates, no repeat.
REQ-017 REPEAT: sync_p=0 -> REL_CHK; rpt_en=0 -> HELD, counter saturated; counter reaching RPT_PERIOD-1 -> key_repeat pulse, counter cleared.
REQ-018 REL_CHK: key_level stays 1; sync_p=1 -> HELD, counter cleared (repeat delay restarts, no key_press); counter reaching DB_CYCLES-1 with sync_p=0 -> IDLE, key_release pulse, key_level<=0.
REQ-019 All outputs SHALL be registered; no pulse SHALL exceed one cycle; key_press, key_repeat and key_release of one channel are mutually exclusive in any cycle.
REQ-020 Simultaneous events on different channels SHALL produce pulses in the same cycle with no arbitration or masking.
REQ-021 Counters SHALL never wrap; saturation applies wherever no transition is taken.

Reset
REQ-022 KEY[0]=0 SHALL asynchronously force all FSMs to IDLE, counters to 0, synchronizer flops to 1 (released), and key_level, key_press, key_release, key_repeat to 0.
REQ-023 After reset deassertion with a button already held, the channel SHALL follow REQ-013/014 and issue key_press DB_CYCLES+3 edges later; no key_release is issued for a press interrupted by reset.

Verification (DB_CYCLES=8, RPT_DELAY=20, RPT_PERIOD=5)
REQ-024 KEY[1] low at edge 1 for 40 edges, rpt_en=0 -> key_press[0] at edge 11, key_level[0]=1 from edge 11, no key_repeat; KEY[1] high at edge 41 -> key_release[0] at edge 51.
REQ-025 KEY[2] low for 5 edges, then high -> all outputs stay 0.
REQ-026 rpt_en[2]=1, KEY[3] low from edge 1 for 50 edges -> key_press[2] at 11, key_repeat[2] at 31, 36, 41, 46, 51.
REQ-027 KEY[1] held to HELD, then high for 3 edges and low again -> no key_release, key_level[0] stays 1, repeat delay restarts from re-entry to HELD.
REQ-028 KEY[1] and KEY[3] low on the same edge -> key_press[0] and key_press[2] high in the same cycle.
REQ-029 KEY[0] pulsed low mid-hold (KEY[2] low) -> all outputs 0 without a clock edge; after reset release with KEY[2] still low -> key_press[1] 11 edges later.
